// File: rtl/dff_pipe.sv
// Valid/ready register pipeline of DEPTH stages. Each stage moves forward when its own ready is high.
// Optional synchronous flush port (flush_i) is compiled in by defining DFF_PIPE_FLUSH_EN.
module dff_pipe #(
  parameter int              WIDTH    = 8,
  parameter int              DEPTH    = 3,
  parameter int              RST_MODE = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic                       flush_i,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [1:0]       sync_q;
  logic             rst_sync;
  logic             flush;
  logic             in_fire;
  logic             all_full;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [OCC_W-1:0] occ;

`ifdef DFF_PIPE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Reset release synchronizer: set at once by reset, clears on the 2nd clk edge after reset falls.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], 1'b0};
  end
  assign rst_sync = sync_q[1];

  // ready_k = !valid_k || ready_{k+1}, unrolled: a stage is ready unless it and every stage after
  // it are full and the sink is stalled. Unrolling avoids a combinational self-loop on one vector.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    all_full = 1'b1;
    ready    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      ready[k] = out_ready_i | ~all_full;
    end
  end

  assign in_ready_o = ready[0] & ~rst_sync & ~flush;
  assign in_fire    = in_valid_i & in_ready_o;

  for (genvar k = 0; k < DEPTH; k++) begin : g_up
    if (k == 0) begin : g_head
      assign up_valid[k] = in_fire;
      assign up_data[k]  = in_data_i;
    end else begin : g_body
      assign up_valid[k] = valid_q[k-1];
      assign up_data[k]  = data_q[k-1];
    end
    assign load[k] = ready[k] & up_valid[k] & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ready[k]) valid_q[k] <= up_valid[k];
      end
    end
  end

  if (RST_MODE == 2) begin : g_data_async
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (load[k]) data_q[k] <= up_data[k];
        end
      end
    end
  end else if (RST_MODE == 1) begin : g_data_sync
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (load[k]) data_q[k] <= up_data[k];
        end
      end
    end
  end else begin : g_data_noreset
    // NOTE: data storage is left unreset on purpose; valid_q alone marks what it means.
    always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) data_q[k] <= up_data[k];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(valid_q[k]);
  end

  assign occupancy_o = occ;
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Scenario bench for dff_pipe (DEPTH=3, async data reset to a non-zero RST_VAL).
// Define DFF_PIPE_FLUSH_EN for both files to include the flush scenario.
module tb_dff_pipe;

  localparam int             WIDTH = 8;
  localparam int             DEPTH = 3;
  localparam int             OCC_W = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RST_V = 8'h5A;

  logic             clk;
  logic             reset;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic [OCC_W-1:0] occupancy_o;
`ifdef DFF_PIPE_FLUSH_EN
  logic             flush_i;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb_q[$];

  dff_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RST_MODE(2), .RST_VAL(RST_V)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
`ifdef DFF_PIPE_FLUSH_EN
    .flush_i(flush_i),
`endif
    .occupancy_o(occupancy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 2 time units after posedge; at negedge both sides hold what the next edge sees.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, expected no output", out_data_o);
        end else begin
          logic [WIDTH-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (out_data_o !== exp_d) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", out_data_o, exp_d);
          end
        end
      end
      if (in_valid_i && in_ready_o) sb_q.push_back(in_data_i);
    end
  end

  task automatic test_reset();
    reset = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
`ifdef DFF_PIPE_FLUSH_EN
    flush_i = 1'b0;
`endif
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || occupancy_o !== '0 || in_ready_o !== 1'b0 || out_data_o !== RST_V) begin
      errors++;
      $display("FAIL reset_state: valid=%b occ=%0d ready=%b data=%h expected 0 0 0 %h",
               out_valid_o, occupancy_o, in_ready_o, out_data_o, RST_V);
    end
    @(posedge clk); #2 reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready_o !== (e == 2) || out_valid_o !== 1'b0 || occupancy_o !== '0) begin
        errors++;
        $display("FAIL reset_release edge%0d: ready=%b valid=%b occ=%0d expected ready=%b",
                 e, in_ready_o, out_valid_o, occupancy_o, e == 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [3] = '{8'h11, 8'h22, 8'h33};
    int               exp_occ [6] = '{1, 2, 3, 2, 1, 0};
    @(posedge clk); #2;
    out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = words[0];
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #2;
      in_valid_i = (cyc < 3);
      in_data_i  = (cyc < 3) ? words[cyc] : '0;
      @(negedge clk);
      checks++;
      if (occupancy_o !== OCC_W'(exp_occ[cyc-1]) || out_valid_o !== (cyc >= 3 && cyc <= 5)) begin
        errors++;
        $display("FAIL b2b cycle%0d: occ=%0d valid=%b expected occ=%0d valid=%b",
                 cyc, occupancy_o, out_valid_o, exp_occ[cyc-1], cyc >= 3 && cyc <= 5);
      end
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (out_data_o !== words[cyc-3]) begin
          errors++;
          $display("FAIL b2b_data cycle%0d: got %h expected %h", cyc, out_data_o, words[cyc-3]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    @(posedge clk); #2;
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1; in_data_i = words[i];
      @(negedge clk);
      checks++;
      if (in_ready_o !== (i < 3)) begin
        errors++;
        $display("FAIL bp_accept word%0d: ready=%b expected %b", i, in_ready_o, i < 3);
      end
      @(posedge clk); #2;
    end
    in_valid_i = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checks++;
      if (in_ready_o !== 1'b0 || occupancy_o !== OCC_W'(3) || out_valid_o !== 1'b1 || out_data_o !== words[0]) begin
        errors++;
        $display("FAIL bp_hold cycle%0d: ready=%b occ=%0d valid=%b data=%h expected 0 3 1 %h",
                 h, in_ready_o, occupancy_o, out_valid_o, out_data_o, words[0]);
      end
      @(posedge clk); #2;
    end
    out_ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== words[j]) begin
        errors++;
        $display("FAIL bp_drain word%0d: valid=%b data=%h expected 1 %h", j, out_valid_o, out_data_o, words[j]);
      end
      @(posedge clk); #2;
    end
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || occupancy_o !== '0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b occ=%0d expected 0 0", out_valid_o, occupancy_o);
    end
  endtask

  task automatic test_full_through();
    @(posedge clk); #2;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = 8'hB1 + WIDTH'(i);
      @(posedge clk); #2;
    end
    in_data_i = 8'hB4; out_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1 || occupancy_o !== OCC_W'(3)) begin
      errors++;
      $display("FAIL full_pass_ready: ready=%b occ=%0d expected 1 3", in_ready_o, occupancy_o);
    end
    @(posedge clk); #2;
    in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy_o !== OCC_W'(3) || out_valid_o !== 1'b1 || out_data_o !== 8'hB2) begin
      errors++;
      $display("FAIL full_pass_after: occ=%0d valid=%b data=%h expected 3 1 b2",
               occupancy_o, out_valid_o, out_data_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (occupancy_o !== '0) begin
      errors++;
      $display("FAIL full_pass_drain: occ=%0d expected 0", occupancy_o);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #2;
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 8'hC1;
    @(posedge clk); #2 in_data_i = 8'hC2;
    @(posedge clk); #2 in_valid_i = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (out_valid_o !== 1'b1 || occupancy_o !== OCC_W'(2) || out_data_o !== 8'hC1) begin
      errors++;
      $display("FAIL rmid_pre: valid=%b occ=%0d data=%h expected 1 2 c1", out_valid_o, occupancy_o, out_data_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || occupancy_o !== '0 || out_data_o !== RST_V || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: valid=%b occ=%0d data=%h ready=%b expected 0 0 %h 0",
               out_valid_o, occupancy_o, out_data_o, in_ready_o, RST_V);
    end
    sb_q.delete();
    @(posedge clk); #2 reset = 1'b0; out_ready_i = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #2;
      checks++;
      if (in_ready_o !== (e == 2)) begin
        errors++;
        $display("FAIL rmid_release edge%0d: ready=%b expected %b", e, in_ready_o, e == 2);
      end
    end
  endtask

`ifdef DFF_PIPE_FLUSH_EN
  task automatic test_flush();
    @(posedge clk); #2;
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 8'hD1;
    @(posedge clk); #2 in_data_i = 8'hD2;
    @(posedge clk); #2;
    flush_i = 1'b1; in_data_i = 8'hD3;
    #1;
    checks++;
    if (in_ready_o !== 1'b0 || occupancy_o !== OCC_W'(2)) begin
      errors++;
      $display("FAIL flush_ready: ready=%b occ=%0d expected 0 2", in_ready_o, occupancy_o);
    end
    @(posedge clk); #2;
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    sb_q.delete();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (occupancy_o !== '0 || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_clear cycle%0d: occ=%0d valid=%b expected 0 0", c, occupancy_o, out_valid_o);
      end
      @(posedge clk); #2;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_through();
    test_reset_mid();
`ifdef DFF_PIPE_FLUSH_EN
    test_flush();
`endif
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d words never emerged, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
